l1_fill_sequencer: RTL and testbench

L1_FILL_SEQUENCER -- requirements
Module: l1_fill_sequencer

---
 rtl/l1_fill_sequencer_if.sv | 34 +++
 rtl/l1_fill_sequencer.sv | 111 +++++++++++
 tb/tb_l1_fill_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_fill_sequencer_if.sv
// Request, memory-burst and fill-data channels of the L1 line-fill sequencer.
// The slave modport is the sequencer; master is the icache/memory side.
interface l1_fill_sequencer_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [4:0]  req_size;
  logic        req_ack;

  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic [4:0]  mem_req_len;
  logic        mem_req_ready;

  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        mem_rdata_ready;

  logic        data_valid;
  logic [31:0] data;
  logic        line_done;
  logic        fill_error;

  modport master (
    output req_valid, req_addr, req_size, mem_req_ready, mem_rdata_valid, mem_rdata,
    input  req_ack, mem_req_valid, mem_req_addr, mem_req_len, mem_rdata_ready,
           data_valid, data, line_done, fill_error
  );

  modport slave (
    input  req_valid, req_addr, req_size, mem_req_ready, mem_rdata_valid, mem_rdata,
    output req_ack, mem_req_valid, mem_req_addr, mem_req_len, mem_rdata_ready,
           data_valid, data, line_done, fill_error
  );
endinterface

// File: rtl/l1_fill_sequencer.sv
// L1 icache line-fill sequencer: accepts a miss, issues one memory burst and
// streams the returned words to the icache with a fixed one-cycle latency.
//
// state | meaning
// IDLE  | waiting for a miss request; ack is given combinationally
// ISSUE | burst request held on the memory port until accepted
// DATA  | collecting beats; exits on the last beat or on idle-beat timeout
module l1_fill_sequencer #(
  parameter int LINE_W               = 8,
  parameter int MAX_OUTSTANDING_WAIT = 255
) (
  input  logic                clk,
  input  logic                rst,
  l1_fill_sequencer_if.slave  bus
);
  localparam int                WAIT_W    = $clog2(MAX_OUTSTANDING_WAIT + 1);
  localparam logic [31:0]       ADDR_MASK = ~(32'(LINE_W * 4) - 32'd1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MAX_OUTSTANDING_WAIT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

  state_t            state, state_nxt;
  logic [4:0]        beat_cnt, beat_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [31:0]       addr_q;
  logic [4:0]        len_q;
  logic              data_valid_q, line_done_q, fill_error_q;
  logic [31:0]       data_q;
  logic              capture, accept, last_beat, timeout;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    accept       = 1'b0;
    last_beat    = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.mem_req_ready) begin
          state_nxt    = DATA;
          beat_cnt_nxt = '0;
          wait_cnt_nxt = WAIT_LOAD;
        end
      end
      DATA: begin
        if (bus.mem_rdata_valid) begin
          accept       = 1'b1;
          beat_cnt_nxt = beat_cnt + 5'd1;
          wait_cnt_nxt = WAIT_LOAD;
          if (beat_cnt == len_q) begin
            last_beat = 1'b1;
            state_nxt = IDLE;
          end
        end else if (wait_cnt == '0) begin
          // terminal count reached on the last allowed silent cycle
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      wait_cnt     <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
      line_done_q  <= 1'b0;
      fill_error_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      wait_cnt     <= wait_cnt_nxt;
      if (capture) begin
        addr_q <= bus.req_addr & ADDR_MASK;
        len_q  <= bus.req_size;
      end
      data_valid_q <= accept;
      data_q       <= accept ? bus.mem_rdata : 32'd0;
      line_done_q  <= last_beat;
      if (timeout || (bus.mem_rdata_valid && (state != DATA)))
        fill_error_q <= 1'b1;
    end
  end

  // ack is gated by rst so it is also forced low while reset is held
  assign bus.req_ack         = (state == IDLE) && bus.req_valid && rst;
  assign bus.mem_req_valid   = (state == ISSUE);
  assign bus.mem_req_addr    = addr_q;
  assign bus.mem_req_len     = len_q;
  assign bus.mem_rdata_ready = (state == DATA);
  assign bus.data_valid      = data_valid_q;
  assign bus.data            = data_q;
  assign bus.line_done       = line_done_q;
  assign bus.fill_error      = fill_error_q;
endmodule

// File: tb/tb_l1_fill_sequencer.sv
// Randomized and directed bench for l1_fill_sequencer, checked every cycle
// against a line-level behavioural model of the fill protocol.
module tb_l1_fill_sequencer;
  localparam int LINE_W = 8;
  localparam int MAXW   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  l1_fill_sequencer_if bus ();

  l1_fill_sequencer #(.LINE_W(LINE_W), .MAX_OUTSTANDING_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req_ack"},         32'(bus.req_ack), 0);
    chk({tag, ".mem_req_valid"},   32'(bus.mem_req_valid), 0);
    chk({tag, ".mem_req_addr"},    bus.mem_req_addr, 0);
    chk({tag, ".mem_req_len"},     32'(bus.mem_req_len), 0);
    chk({tag, ".mem_rdata_ready"}, 32'(bus.mem_rdata_ready), 0);
    chk({tag, ".data_valid"},      32'(bus.data_valid), 0);
    chk({tag, ".data"},            bus.data, 0);
    chk({tag, ".line_done"},       32'(bus.line_done), 0);
    chk({tag, ".fill_error"},      32'(bus.fill_error), 0);
  endtask

  // ---------------- behavioural model ----------------
  bit          m_have, m_sent, m_err;
  int          m_got, m_silent;
  logic [31:0] m_base;
  logic [4:0]  m_len;
  bit          p_valid, p_last;
  logic [31:0] p_data;
  bit          e_ack, e_mrv, e_rdy, acc;

  // monitor records used by the hand-computed directed expectations
  logic [31:0] mon_data[$];
  int          mon_cyc[$];
  bit          mon_last[$];
  int          ack_cycles, issue_cycles;
  logic [31:0] last_req_addr;
  logic [4:0]  last_req_len;

  always @(negedge clk) begin
    if (!rst) begin
      m_have = 0; m_sent = 0; m_err = 0; m_got = 0; m_silent = 0;
      m_base = 0; m_len = 0; p_valid = 0; p_last = 0; p_data = 0;
      chk_zero("in_reset");
    end else begin
      e_ack = !m_have && bus.req_valid;
      e_mrv = m_have && !m_sent;
      e_rdy = m_have && m_sent;
      chk("req_ack",         32'(bus.req_ack), 32'(e_ack));
      chk("mem_req_valid",   32'(bus.mem_req_valid), 32'(e_mrv));
      chk("mem_rdata_ready", 32'(bus.mem_rdata_ready), 32'(e_rdy));
      if (e_mrv) begin
        chk("mem_req_addr", bus.mem_req_addr, m_base);
        chk("mem_req_len",  32'(bus.mem_req_len), 32'(m_len));
      end
      chk("data_valid", 32'(bus.data_valid), 32'(p_valid));
      chk("data",       bus.data, p_data);
      chk("line_done",  32'(bus.line_done), 32'(p_last));
      chk("fill_error", 32'(bus.fill_error), 32'(m_err));

      if (bus.data_valid) begin
        mon_data.push_back(bus.data);
        mon_cyc.push_back(cyc);
        mon_last.push_back(bus.line_done);
      end
      if (bus.req_ack) ack_cycles++;
      if (bus.mem_req_valid) begin
        issue_cycles++;
        last_req_addr = bus.mem_req_addr;
        last_req_len  = bus.mem_req_len;
      end

      // advance the model across the coming rising edge
      acc     = e_rdy && bus.mem_rdata_valid;
      p_valid = acc;
      p_data  = acc ? bus.mem_rdata : 32'd0;
      p_last  = acc && (m_got == int'(m_len));
      if (bus.mem_rdata_valid && !e_rdy) m_err = 1;
      if (e_rdy) begin
        if (acc) begin
          if (m_got == int'(m_len)) m_have = 0;
          m_got++;
          m_silent = 0;
        end else begin
          m_silent++;
          if (m_silent == MAXW) begin
            m_have = 0;
            m_err  = 1;
          end
        end
      end
      if (e_mrv && bus.mem_req_ready) begin
        m_sent = 1; m_got = 0; m_silent = 0;
      end
      if (e_ack) begin
        m_have = 1; m_sent = 0;
        m_base = bus.req_addr & ~(32'(LINE_W * 4) - 32'd1);
        m_len  = bus.req_size;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete(); mon_cyc.delete(); mon_last.delete();
    ack_cycles = 0; issue_cycles = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.req_valid = 0; bus.mem_req_ready = 0; bus.mem_rdata_valid = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic run_fill(input logic [31:0] addr, input int rdy_delay, input int gap,
                          input int nbeats, input logic [31:0] dbase, input bit rnd_data,
                          input bit pre_acked, input bit chain, input logic [31:0] chain_addr,
                          output int ack_wait);
    bit ok;
    ack_wait = 0;
    if (!pre_acked) begin
      bus.req_valid = 1; bus.req_addr = addr; bus.req_size = 5'(LINE_W - 1);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        #1;
        if (bus.req_ack) begin ok = 1; ack_wait = i; break; end
        tick();
      end
      chk("req_ack_seen", 32'(ok), 1);
      tick();
      bus.req_valid = 0;
    end
    repeat (rdy_delay) tick();
    bus.mem_req_ready = 1;
    tick();
    bus.mem_req_ready = 0;
    for (int i = 0; i < nbeats; i++) begin
      if (i > 0) repeat ((gap < 0) ? $urandom_range(0, 3) : gap) tick();
      if (chain && i == 0) begin
        bus.req_valid = 1; bus.req_addr = chain_addr; bus.req_size = 5'(LINE_W - 1);
      end
      bus.mem_rdata_valid = 1;
      bus.mem_rdata = rnd_data ? $urandom : dbase + 32'(i);
      tick();
      bus.mem_rdata_valid = 0;
      bus.mem_rdata = $urandom;
    end
    if (chain) begin
      chk("b2b_ack_with_last_data", {29'd0, bus.req_ack, bus.data_valid, bus.line_done}, 7);
      tick();
      bus.req_valid = 0;
    end
  endtask

  task automatic check_mon(input string tag, input int n, input logic [31:0] dbase,
                           input int spacing, input bit expect_done);
    chk({tag, ".words"}, 32'(mon_data.size()), 32'(n));
    for (int i = 0; i < n && i < mon_data.size(); i++) begin
      chk({tag, ".word"}, mon_data[i], dbase + 32'(i));
      chk({tag, ".line_done"}, 32'(mon_last[i]), 32'(expect_done && (i == n - 1)));
      if (i > 0 && spacing > 0) chk({tag, ".spacing"}, 32'(mon_cyc[i] - mon_cyc[i-1]), 32'(spacing));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int aw;
    logic [31:0] addr, next_addr;
    bit pre, chain_next;
    int n;

    bus.req_valid = 0; bus.req_addr = 0; bus.req_size = 5'(LINE_W - 1);
    bus.mem_req_ready = 0; bus.mem_rdata_valid = 0; bus.mem_rdata = 0;
    tick(); tick();
    chk_zero("reset_state");
    rst = 1'b1;

    // basic fill, request raised in the first cycle after reset release
    clear_mon();
    run_fill(32'h0000_1234, 0, 0, 8, 32'hA0, 0, 0, 0, 0, aw);
    tick(); tick();
    chk("first_req_ack_wait", 32'(aw), 0);
    chk("basic.ack_cycles", 32'(ack_cycles), 1);
    chk("basic.mem_req_addr", last_req_addr, 32'h0000_1220);
    chk("basic.mem_req_len", 32'(last_req_len), 7);
    check_mon("basic", 8, 32'hA0, 1, 1);

    // memory stall: ready low 5 cycles, 2-cycle gaps between beats
    clear_mon();
    run_fill(32'h0000_5678, 5, 2, 8, 32'hB0, 0, 0, 0, 0, aw);
    tick(); tick();
    chk("stall.issue_cycles", 32'(issue_cycles), 6);
    chk("stall.mem_req_addr", last_req_addr, 32'h0000_5660);
    check_mon("stall", 8, 32'hB0, 3, 1);

    // back-to-back: req_valid held through fill 1
    clear_mon();
    run_fill(32'h1000_0044, 0, 0, 8, 32'hC0, 0, 0, 1, 32'h2000_00FC, aw);
    run_fill(32'h2000_00FC, 0, 1, 8, 32'hD0, 0, 1, 0, 0, aw);
    tick(); tick();
    chk("b2b.ack_cycles", 32'(ack_cycles), 2);
    chk("b2b.mem_req_addr", last_req_addr, 32'h2000_00E0);
    chk("b2b.words", 32'(mon_data.size()), 16);

    // timeout: 3 beats then silence
    apply_reset();
    clear_mon();
    run_fill(32'h0000_0300, 0, 0, 3, 32'hE0, 0, 0, 0, 0, aw);
    repeat (15) tick();
    chk("timeout.err_before", 32'(bus.fill_error), 0);
    tick();
    chk("timeout.err_at_16", 32'(bus.fill_error), 1);
    chk("timeout.rdata_ready", 32'(bus.mem_rdata_ready), 0);
    check_mon("timeout", 3, 32'hE0, 1, 0);
    clear_mon();
    run_fill(32'h0000_0400, 0, 0, 8, 32'hF0, 0, 0, 0, 0, aw);
    tick(); tick();
    check_mon("after_timeout", 8, 32'hF0, 1, 1);

    // spurious beat while idle
    apply_reset();
    clear_mon();
    bus.mem_rdata_valid = 1; bus.mem_rdata = 32'h5555_5555;
    tick();
    bus.mem_rdata_valid = 0;
    chk("spurious.err", 32'(bus.fill_error), 1);
    tick();
    chk("spurious.no_data", 32'(mon_data.size()), 0);
    run_fill(32'h0000_0800, 1, 0, 8, 32'h60, 0, 0, 0, 0, aw);
    tick(); tick();
    chk("spurious.err_sticky", 32'(bus.fill_error), 1);
    check_mon("spurious_fill", 8, 32'h60, 1, 1);

    // reset mid-burst after beat 4
    apply_reset();
    clear_mon();
    run_fill(32'h0000_0900, 0, 0, 4, 32'h70, 0, 0, 0, 0, aw);
    chk("midrst.dv_before", 32'(bus.data_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midrst_async");
    tick(); tick();
    rst = 1'b1;
    clear_mon();
    for (int i = 4; i < 8; i++) begin
      bus.mem_rdata_valid = 1; bus.mem_rdata = 32'h70 + 32'(i);
      tick();
    end
    bus.mem_rdata_valid = 0;
    tick();
    chk("midrst.dropped", 32'(mon_data.size()), 0);
    chk("midrst.err", 32'(bus.fill_error), 1);
    run_fill(32'h0000_0A00, 0, 0, 8, 32'h80, 0, 0, 0, 0, aw);
    tick(); tick();
    check_mon("midrst_fill", 8, 32'h80, 1, 1);

    // randomized fills, chains and timeouts
    apply_reset();
    pre  = 0;
    addr = $urandom;
    for (int k = 0; k < 40; k++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 8;
      chain_next = (n == 8) && ($urandom_range(0, 3) == 0);
      next_addr  = $urandom;
      run_fill(addr, $urandom_range(0, 4), -1, n, 0, 1, pre, chain_next, next_addr, aw);
      if (n < 8) repeat (MAXW + 2) tick();
      else if (!chain_next) repeat ($urandom_range(1, 3)) tick();
      pre  = chain_next;
      addr = chain_next ? next_addr : $urandom;
    end
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
